// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
// Holds the sequencer state enum, requester index type and port ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef logic port_t;

    localparam port_t PORT_CPU = 1'b0;
    localparam port_t PORT_LDR = 1'b1;

    // One-hot round-robin pick for two requesters.
    // On a tie the port that did not win last time is chosen.
    function automatic logic [1:0] rr_pick(
        input logic [1:0] req,
        input port_t      last
    );
        logic [1:0] g;
        g = 2'b00;
        unique case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = (last == PORT_CPU) ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with enable and one-hot grant.
// Ports: i_clk, i_reset (sync, active-high), i_en, i_req[1:0] -> o_gnt[1:0].
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    port_t      r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            w_gnt = rr_pick(i_req, r_last);
        end
    end

    assign o_gnt = w_gnt;

    // Reset to the loader so the CPU wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last <= PORT_LDR;
        end else if (w_gnt[1]) begin
            r_last <= PORT_LDR;
        end else if (w_gnt[0]) begin
            r_last <= PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU (port 0)
// and the loader/debug port (port 1) with round-robin arbitration, a
// registered one-cycle read path and an optional zero-fill engine.
// Build option: define MEM_ARB_CLEAR_EN to enable the clear engine.
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   req/we/addr/wdata 0,1   requester inputs, held until granted
//   gnt0/1                  combinational grant
//   rvalid0/1, rdata        registered read response
//   clr_start/busy/done     clear engine control and status
//   mem_we/addr/wdata/rdata memory port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int A = 6,
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [A-1:0] addr0,
    input  logic [A-1:0] addr1,
    input  logic [W-1:0] wdata0,
    input  logic [W-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [W-1:0] rdata,
    input  logic         clr_start,
    output logic         clr_busy,
    output logic         clr_done,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata
);

    logic         w_arb_en;
    logic         w_clearing;
    logic         w_done;
    logic [A-1:0] w_clr_addr;
    logic [1:0]   w_gnt;
    logic         w_rd0;
    logic         w_rd1;
    logic [1:0]   r_rvalid;
    logic [W-1:0] r_rdata;

`ifdef MEM_ARB_CLEAR_EN

    arb_state_t   r_state;
    arb_state_t   w_state_nxt;
    logic [A-1:0] r_cnt;
    logic         w_cnt_last;

    // Terminal compare on all-ones: the last address is written
    // before leaving CLEAR, so the counter never wraps early.
    assign w_cnt_last = &r_cnt;
    assign w_clr_addr = r_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (clr_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (w_cnt_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A start request in IDLE pre-empts arbitration for that cycle.
    always_comb begin
        w_arb_en   = 1'b1;
        w_clearing = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_arb_en = ~clr_start;
            end
            CLEAR: begin
                w_arb_en   = 1'b0;
                w_clearing = 1'b1;
            end
            DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_arb_en = 1'b0;
            end
        endcase
    end

`else

    logic w_unused_clr;

    assign w_unused_clr = clr_start;
    assign w_arb_en     = 1'b1;
    assign w_clearing   = 1'b0;
    assign w_done       = 1'b0;
    assign w_clr_addr   = '0;

`endif

    rr_arb2 u_arb (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_en    (w_arb_en),
        .i_req   ({req1, req0}),
        .o_gnt   (w_gnt)
    );

    assign gnt0 = w_gnt[0];
    assign gnt1 = w_gnt[1];

    // Memory drive is all-zero unless a port is granted or a clear runs,
    // so the level-sensitive write can never fire spuriously.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_clearing) begin
            mem_we   = 1'b1;
            mem_addr = w_clr_addr;
        end else if (w_gnt[0]) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (w_gnt[1]) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign w_rd0 = w_gnt[0] & ~we0;
    assign w_rd1 = w_gnt[1] & ~we1;

    // rdata only moves on a granted read, so it holds between reads.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rvalid <= 2'b00;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= {w_rd1, w_rd0};
            if (w_rd0 | w_rd1) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign rvalid0  = r_rvalid[0];
    assign rvalid1  = r_rvalid[1];
    assign rdata    = r_rdata;
    assign clr_busy = w_clearing;
    assign clr_done = w_done;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer in front of the single-port data/instruction `memory` (combinational read, level write on `write_enable`). It shares the one memory port between two requesters, port 0 (CPU load/store) and port 1 (loader/debug), using round-robin arbitration. It registers read data for a fixed one-cycle latency. An optional clear engine zero-fills the whole array.

## Interface
- `A`, 6: memory address width; array depth is 2^A.
- `W`, 8: memory data width.
- `Clk` input 1: clock; all state updates on rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1: access request, held until granted.
- `we0`, `we1` input 1: 1 = write, 0 = read; valid with req.
- `addr0`, `addr1` input A: access address.
- `wdata0`, `wdata1` input W: write data.
- `gnt0`, `gnt1` output 1: combinational grant; access performed this cycle.
- `rvalid0`, `rvalid1` output 1: registered; read data valid, one cycle after a granted read.
- `rdata` output W: registered read data (shared; qualified by rvalid0/1).
- `clr_start` input 1: pulse to start a zero-fill (clear build only).
- `clr_busy` output 1: clear in progress.
- `clr_done` output 1: one-cycle pulse when the clear finishes.
- `mem_we` output 1: to memory `write_enable`.
- `mem_addr` output A: to memory `InstAddress`.
- `mem_wdata` output W: to memory `InputData`.
- `mem_rdata` input W: from memory `InstrOut`.

## Operation
- States: IDLE, CLEAR, DONE. Arbitration is active in IDLE and DONE only.
- Only one requester asserting: grant it.
- Both requesters asserting: grant the port not granted most recently.
- `last` pointer: updated on every grant; reset value 1, so port 0 wins the first tie.
- Memory drive:
  - Granted port's we/addr/wdata drive `mem_*`.
  - No grant: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `mem_we` is never 1 without a grant or CLEAR; the memory write is level-sensitive.
- Granted read: `rdata` <= `mem_rdata` at the edge; the granted port's rvalid=1 the next cycle only.
- Granted write: no rvalid pulse.
- `rdata` holds its value between reads.
- Requester holds req/we/addr/wdata stable until it sees gnt=1 at a clock edge. It may drop req or issue a new request the next cycle.
- CLEAR sequence:
  - IDLE with `clr_start`=1 → CLEAR; counter=0.
  - Each CLEAR cycle: `mem_we`=1, `mem_addr`=counter, `mem_wdata`=0; counter increments.
  - Counter wraps at 2^A−1 → DONE.
  - DONE lasts one cycle with `clr_done`=1, then → IDLE.
- `clr_busy`=1 exactly in CLEAR; no grants while in CLEAR.
- `clr_start` in CLEAR or DONE: ignored.
- `clr_start` with req in the same IDLE cycle: clear wins; no grant that cycle.
- Counter is A+1 bits or uses a terminal-compare on all-ones; no early wrap.

## Timing
- Reset values: state=IDLE, `last`=1, counter=0, rvalid0/1=0, `rdata`=0, `clr_busy`=0, `clr_done`=0.
- gnt and `mem_*` are combinational and therefore 0 whenever req=0 in IDLE.
- Read latency: req granted at edge N → rvalid/rdata valid in cycle N+1.
- Back-to-back grants to the same or alternating ports are allowed every cycle.
- Clear: `clr_start` sampled at edge N → 2^A write cycles (N+1 … N+2^A) → `clr_done` in cycle N+2^A+1. For A=6 that is 64 writes, with `clr_done` 65 cycles after the start edge.
- Reset mid-clear: abort to IDLE next edge. Memory stays partially cleared; no `clr_done`.
- Reset with a pending read: rvalid suppressed.

## Configuration
- `MEM_ARB_CLEAR_EN` defined: CLEAR/DONE states, counter, and clear ports are active as above.
- Not defined:
  - `clr_start` ignored.
  - `clr_busy` and `clr_done` tied to 0.
  - State machine stays in IDLE.
  - No counter logic is synthesized.
- Arbitration and latency are identical in both builds.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `arb_state_t` {IDLE, CLEAR, DONE};
  - requester index typedef `port_t` (1 bit);
  - constants `PORT_CPU`=0 and `PORT_LDR`=1.
- One sub-module: `rr_arb2`. It is a two-input round-robin grant with an enable input, the `last` register, and one-hot grant out.
- Top-level owns the muxing, read register, and clear sequencer.

## Test plan
- Reset, then port 0 reads addr 5 (preloaded 0x3C) → `gnt0`=1 same cycle; `rvalid0`=1 and `rdata`=0x3C next cycle; `rvalid1`=0.
- Both ports request on three consecutive cycles, addr 1 and addr 2 → grants go 0, 1, 0; each port holds its request until granted.
- Port 1 writes 0xA5 to addr 63, then port 0 reads addr 63 next cycle → `rdata`=0xA5 with `rvalid0`; there is no rvalid after the write.
- Fill the array with 0xFF, pulse `clr_start` with `req0`=1 in the same cycle:
  - no grant during the clear;
  - `clr_busy`=1 for 64 cycles;
  - `clr_done` pulses at cycle 65;
  - all reads then return 0x00.
- Assert `Reset` after 20 clear cycles → next cycle IDLE and `clr_busy`=0; addrs 0–19 read 0x00, addr 20+ still 0xFF; `clr_done` never pulses.
- Build without `MEM_ARB_CLEAR_EN`: pulse `clr_start` → `clr_busy`/`clr_done` stay 0 and concurrent reqs are granted normally.
